// File: rtl/lr_shift_seq.sv
// Bit-serial logical shifter: one position per clock, o_valid max(shift,1) cycles after accept.
// i_ready stays low from accept until the result handshake; the result is held while o_ready is low.
module lr_shift_seq #(
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [width-1:0]         i_bits,
  input  logic [$clog2(width)-1:0] shift,
  input  logic                     dir,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [width-1:0]         o_bits,
  output logic                     busy
);

  localparam int sw = $clog2(width);
  localparam logic [sw-1:0] cnt_one = sw'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [sw-1:0]    count;
  logic             dir_q;
  logic [width-1:0] data;

  assign o_bits = data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      data    <= '0;
      count   <= '0;
      dir_q   <= 1'b0;
      o_valid <= 1'b0;
      i_ready <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            data    <= i_bits;
            count   <= shift;
            dir_q   <= dir;
            i_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= (shift == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data  <= dir_q ? (data >> 1) : (data << 1);
          count <= count - cnt_one;
          if (count == cnt_one) begin
            state   <= DONE;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          // A zero-shift request lands here with o_valid low; raising it one
          // cycle later keeps the minimum latency at one cycle.
          if (!o_valid) begin
            o_valid <= 1'b1;
          end else if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lr_shift_seq.sv
// Scoreboard bench for lr_shift_seq: driver pushes expected results, negedge monitor pops and compares.
module tb_lr_shift_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_bits;
  logic [2:0] shift;
  logic       dir;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] o_bits;
  logic       busy;

  lr_shift_seq #(.width(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_bits(i_bits), .shift(shift), .dir(dir),
    .o_valid(o_valid), .o_ready(o_ready), .o_bits(o_bits), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rmode = 0;
  bit   was_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: logical shift of an 8-bit word, expressed arithmetically.
  function automatic logic [7:0] ref_shift(input logic [7:0] b, input int sh, input bit d);
    int v;
    v = int'(b);
    if (d) v = v / (1 << sh);
    else   v = (v * (1 << sh)) % 256;
    return v[7:0];
  endfunction

  // Monitor: every cycle it checks handshake readiness against the scoreboard
  // occupancy, and compares data/latency whenever a result is presented.
  always @(negedge clk) begin
    if (!rst) begin
      was_valid = 1'b0;
    end else begin
      chk("i_ready", i_ready, sb.size() == 0);
      chk("busy", busy, sb.size() != 0);
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_o_valid", o_valid, 1'b0);
        end else begin
          if (!was_valid) chk("latency", cyc - sb[0].acc, sb[0].lat);
          chk("o_bits", o_bits, sb[0].dat);
          if (o_ready) begin
            void'(sb.pop_front());
            was_valid = 1'b0;
          end else begin
            was_valid = 1'b1;
          end
        end
      end else begin
        if (was_valid) chk("o_valid_dropped", o_valid, 1'b1);
        was_valid = 1'b0;
      end
    end
  end

  initial begin
    o_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       o_ready = 1'b1;
        1:       o_ready = 1'($urandom_range(0, 1));
        default: o_ready = 1'b0;
      endcase
    end
  end

  task automatic issue(input logic [7:0] b, input int sh, input bit d);
    int   n;
    exp_t e;
    n = 0;
    i_bits  = b;
    shift   = sh[2:0];
    dir     = d;
    i_valid = 1'b1;
    @(negedge clk);
    while (!i_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!i_ready) begin
      chk("accept_timeout", i_ready, 1'b1);
      i_valid = 1'b0;
      return;
    end
    e.dat = ref_shift(b, sh, d);
    e.lat = (sh == 0) ? 1 : sh;
    e.acc = cyc + 1;
    @(posedge clk);
    #1;
    sb.push_back(e);
    i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Keeps i_valid high with changing operands while the request is in flight.
  task automatic noise();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        i_valid = 1'b0;
      end else begin
        i_valid = 1'b1;
        i_bits  = 8'($urandom);
        shift   = 3'($urandom);
        dir     = 1'($urandom);
      end
      n++;
    end
    i_valid = 1'b0;
    if (sb.size() != 0) begin
      chk("noise_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b;
    int sh;
    bit d;

    rst = 1'b0; i_valid = 1'b0; i_bits = '0; shift = '0; dir = 1'b0;
    #12;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_i_ready", i_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_o_bits", o_bits, 8'h00);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_i_ready", i_ready, 1'b1);
    chk("idle_o_valid", o_valid, 1'b0);

    // Left shift, downstream always ready.
    issue(8'h96, 3, 1'b0);
    wait_done();

    // Right shift held under backpressure for 4 cycles.
    rmode = 2;
    @(posedge clk);
    #2;
    issue(8'h96, 5, 1'b1);
    n = 0;
    while (!o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_o_valid", o_valid, 1'b1);
    repeat (4) @(posedge clk);
    rmode = 0;
    wait_done();

    // Zero and maximum shift.
    issue(8'hA5, 0, 1'b0);
    wait_done();
    issue(8'h81, 7, 1'b0);
    wait_done();
    issue(8'h81, 7, 1'b1);
    wait_done();

    // Operand churn and i_valid while busy.
    issue(8'h3C, 4, 1'b1);
    noise();
    issue(8'hC3, 0, 1'b1);
    noise();

    // Asynchronous reset in the middle of a shift-6 request.
    issue(8'h55, 6, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_o_valid", o_valid, 1'b0);
    chk("arst_i_ready", i_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_o_bits", o_bits, 8'h00);
    sb.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_o_valid", o_valid, 1'b0);
    issue(8'h01, 2, 1'b0);
    wait_done();

    // Randomized requests with random backpressure.
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      sh = int'($urandom_range(0, 7));
      d  = 1'($urandom);
      rmode = int'($urandom_range(0, 1));
      issue(b, sh, d);
      if ($urandom_range(0, 1) == 1) noise();
      else wait_done();
    end
    rmode = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lr_shift_seq.md
Name: lr_shift_seq

Overview:
Sequential, bit-serial counterpart of the combinational left-right shifter. It accepts a word, a shift amount and a direction over a valid/ready handshake, then shifts one position per clock. It presents the result on a valid/ready output handshake. It is used where area matters more than latency and a full barrel shifter is not justified.

Parameters:
width, 8, bit width of the data word (legal: width >= 2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
i_valid  in  1  input word, shift and dir are valid
i_ready  out  1  block can accept a new request
i_bits  in  width  data word to shift
shift  in  clog2(width)  requested shift amount, unsigned
dir  in  1  ShiftDir: Left = 0, Right = 1
o_valid  out  1  o_bits holds a completed result
o_ready  in  1  downstream accepts the result
o_bits  out  width  shifted result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (rst = 0, async) forces the following, regardless of any operation in progress:
  - state = IDLE
  - o_bits = 0, o_valid = 0, i_ready = 1, busy = 0
  - internal count = 0, internal dir register = Left
  - Any in-flight operation is discarded. No output is produced for it after reset deasserts.
- State machine (IDLE, SHIFT, DONE):
  - IDLE: i_ready = 1. On i_valid & i_ready:
    - data register <= i_bits, count <= shift, dir register <= dir.
    - Go to DONE if shift == 0, else go to SHIFT.
  - SHIFT: i_ready = 0.
    - Each cycle: data register shifts one position toward the latched dir, zero-filled (logical shift for both directions). count decrements by 1.
    - When count == 1, that cycle's shift is the last one and the state goes to DONE.
  - DONE: o_valid = 1, o_bits = data register, held stable while o_ready = 0.
    - On o_valid & o_ready, go to IDLE, o_valid <= 0.
    - o_bits holds its last value in IDLE; it is don't-care for checking.
- Latency: the accept edge is cycle 0; o_valid rises max(shift,1) cycles later. shift = 0 takes 1 cycle and yields o_bits = i_bits.
- Throughput: one request per (latency + handshake) cycles. No overlap: i_ready stays 0 from accept until the output handshake completes.
- Inputs (i_bits, shift, dir) are sampled only on the accept edge. Changes at any other time have no effect.
- Maximum shift is width-1. No shift amount out of range is possible, because the shift port is clog2(width) wide. For width not a power of 2, values >= width are legal and shift every bit out, giving o_bits = 0.
- i_valid while busy is ignored; the request is neither accepted nor lost silently, because i_ready = 0 signals backpressure.
- o_ready asserted while o_valid = 0 has no effect.
- Result is bit-exact with the combinational shifter:
  - Left: i_bits << shift
  - Right: i_bits >> shift
  - Result truncated to width.

Test Plan:
1. Reset then idle (width 8): o_valid = 0, i_ready = 1, busy = 0; no state change with i_valid = 0.
2. Left shift with o_ready held 1: i_bits = 0x96, shift = 3, dir = Left -> i_ready drops next cycle; o_valid at cycle 3 with o_bits = 0xB0; back to IDLE next cycle.
3. Right shift with backpressure: i_bits = 0x96, shift = 5, dir = Right -> o_valid at cycle 5, o_bits = 0x04; hold o_ready = 0 for 4 cycles -> o_bits and o_valid stable; complete the handshake, then i_ready = 1.
4. Zero and maximum shift: shift = 0 with i_bits = 0xA5 -> o_valid at cycle 1, o_bits = 0xA5. shift = 7 Left with i_bits = 0x81 -> o_bits = 0x80 at cycle 7.
5. Input changes and i_valid while busy: change i_bits, shift and dir every cycle during SHIFT -> result equals the accepted request only, and no second request is accepted until IDLE.
6. Async reset mid-operation: assert rst = 0 in cycle 2 of a shift-6 request -> outputs immediately take reset values; after release, no o_valid appears until a new request is accepted, and that request completes correctly (0x01, Left, 2 -> 0x04).
